// File: rtl/bist_pkg.sv
// Shared types for the BIST march controller and its datapath.
// Pure declarations: no logic, no latency, no flow control.
package bist_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        M_IDLE,
        M_W0_UP,
        M_R0W1_UP,
        M_R1W0_UP,
        M_R0W1_DN,
        M_R1W0_DN,
        M_R0_DN,
        M_DONE
    } march_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } fail_entry_t;

endpackage

// File: rtl/bist_fail_fifo.sv
// Generic sync FIFO for the fail log; head is visible the cycle after push.
// Push while full is dropped (drop pulses) unless a pop happens in the same cycle.
module bist_fail_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full     = (cnt == FULL_CNT);
    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop & head_vld;
    // A pop frees the slot the same cycle, so a full log can still accept.
    assign do_push  = push & (~full | do_pop);
    assign drop     = push & full & ~do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bist_datapath.sv
// BIST datapath: address counter, memory strobes, read-compare pipeline and fail log.
// Compare result lands RD_LAT+1 cycles after mem_re; fail log drained by fail_valid/fail_ready.
module bist_datapath
    import bist_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = 1,
    parameter int LOG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reset,
    input  logic              preset,
    input  logic              en,
    input  logic              up_down,
    input  logic              out,
    input  logic              read,
    input  logic              write,
    output logic              carry,
    output logic              is_equal,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fail_valid,
    input  logic              fail_ready,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic              fail_overflow,
    output logic [7:0]        fail_count
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] expd;
    } cmp_stage_t;

    logic [ADDR_W-1:0]        cnt;
    logic [DATA_W-1:0]        bg;
    cmp_stage_t               pipe [RD_LAT];
    cmp_stage_t               tail;
    logic                     mismatch;
    logic                     log_drop;
    logic [ADDR_W+DATA_W-1:0] head_dat;

    assign bg        = {DATA_W{out}};
    assign mem_addr  = cnt;
    assign mem_wdata = bg;
    assign mem_we    = write & ~reset;
    assign mem_re    = read & ~write & ~reset;
    assign carry     = en & (up_down ? (&cnt) : ~(|cnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (reset) begin
            cnt <= '0;
        end else if (preset) begin
            cnt <= '1;
        end else if (en) begin
            cnt <= up_down ? cnt + ADDR_W'(1) : cnt - ADDR_W'(1);
        end
    end

    // Sync reset only clears the counter; reads already issued still get compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{vld: mem_re, addr: cnt, expd: bg};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail     = pipe[RD_LAT-1];
    assign mismatch = tail.vld & (mem_rdata != tail.expd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_equal      <= 1'b1;
            fail_count    <= '0;
            fail_overflow <= 1'b0;
        end else begin
            if (tail.vld) begin
                is_equal <= (mem_rdata == tail.expd);
            end
            if (mismatch && (fail_count != 8'hFF)) begin
                fail_count <= fail_count + 8'd1;
            end
            if (log_drop) begin
                fail_overflow <= 1'b1;
            end
        end
    end

    bist_fail_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (LOG_DEPTH)
    ) u_fail_log (
        .clk      (clk),
        .rst      (rst),
        .push     (mismatch),
        .push_dat ({tail.addr, mem_rdata}),
        .pop      (fail_ready),
        .head_vld (fail_valid),
        .head_dat (head_dat),
        .drop     (log_drop)
    );

    assign fail_addr = head_dat[ADDR_W+DATA_W-1:DATA_W];
    assign fail_data = head_dat[DATA_W-1:0];

endmodule

// File: tb/tb_bist_datapath.sv
// Directed bench for bist_datapath with RD_LAT=2; memory read data driven by hand.
module tb_bist_datapath;

    logic       clk;
    logic       rst;
    logic       reset;
    logic       preset;
    logic       en;
    logic       up_down;
    logic       out;
    logic       read;
    logic       write;
    logic       carry;
    logic       is_equal;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       fail_valid;
    logic       fail_ready;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic       fail_overflow;
    logic [7:0] fail_count;

    int n_assert = 0;
    int n_fail   = 0;

    bist_datapath #(
        .ADDR_W    (4),
        .DATA_W    (8),
        .RD_LAT    (2),
        .LOG_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reset         (reset),
        .preset        (preset),
        .en            (en),
        .up_down       (up_down),
        .out           (out),
        .read          (read),
        .write         (write),
        .carry         (carry),
        .is_equal      (is_equal),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .fail_valid    (fail_valid),
        .fail_ready    (fail_ready),
        .fail_addr     (fail_addr),
        .fail_data     (fail_data),
        .fail_overflow (fail_overflow),
        .fail_count    (fail_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_assert++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Inputs change at the falling edge; the DUT samples them at the next rising edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic goto_addr(input int a);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        en      = 1'b1;
        up_down = 1'b1;
        repeat (a) tick();
        en = 1'b0;
    endtask

    task automatic single_read(input int a, input logic bgv, input logic [7:0] rd);
        goto_addr(a);
        read = 1'b1;
        out  = bgv;
        tick();
        read = 1'b0;
        tick();
        mem_rdata = rd;
        tick();
        mem_rdata = 8'h00;
    endtask

    initial begin
        logic [3:0] exp_a [4];
        logic [7:0] exp_d [4];
        exp_a = '{4'd1, 4'd2, 4'd3, 4'd7};
        exp_d = '{8'h21, 8'h22, 8'h23, 8'hAA};

        rst = 1'b1; reset = 1'b0; preset = 1'b0; en = 1'b0; up_down = 1'b0;
        out = 1'b0; read = 1'b0; write = 1'b0; fail_ready = 1'b0; mem_rdata = 8'h00;
        @(negedge clk);
        chk("rst_addr", mem_addr, 0);
        chk("rst_eq", is_equal, 1);
        chk("rst_vld", fail_valid, 0);
        chk("rst_ovf", fail_overflow, 0);
        chk("rst_cnt", fail_count, 0);
        chk("rst_carry", carry, 0);
        rst = 1'b0;

        // Count up through the full range and wrap.
        en = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("up_addr", mem_addr, i);
            chk("up_carry", carry, (i == 15));
            tick();
        end
        #1 chk("up_wrap", mem_addr, 0);
        en = 1'b0;

        preset = 1'b1;
        tick();
        preset = 1'b0;
        #1;
        chk("preset", mem_addr, 15);
        chk("carry_en0", carry, 0);

        en = 1'b1; up_down = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            #1;
            chk("dn_addr", mem_addr, i);
            chk("dn_carry", carry, (i == 0));
            tick();
        end
        #1 chk("dn_wrap", mem_addr, 15);

        reset = 1'b1; preset = 1'b1; write = 1'b1; read = 1'b1; out = 1'b1;
        #1;
        chk("we_rst", mem_we, 0);
        chk("re_rst", mem_re, 0);
        tick();
        reset = 1'b0; preset = 1'b0; en = 1'b0;
        #1;
        chk("rst_pri", mem_addr, 0);
        chk("we_wins", mem_we, 1);
        chk("re_blocked", mem_re, 0);
        chk("wdata1", mem_wdata, 8'hFF);
        write = 1'b0; out = 1'b0;
        #1;
        chk("wdata0", mem_wdata, 8'h00);
        chk("re_only", mem_re, 1);
        read = 1'b0;

        // Clean compare at address 3.
        single_read(3, 1'b0, 8'h00);
        #1;
        chk("ok_eq", is_equal, 1);
        chk("ok_cnt", fail_count, 0);
        chk("ok_vld", fail_valid, 0);

        // Mismatch at address 5; counter sync-cleared while the read is in flight.
        goto_addr(5);
        read = 1'b1; out = 1'b1;
        #1;
        chk("rd_addr", mem_addr, 5);
        chk("rd_re", mem_re, 1);
        tick();
        read = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; mem_rdata = 8'hFB;
        #1 chk("pend_eq", is_equal, 1);
        tick();
        mem_rdata = 8'h00;
        #1;
        chk("mm_eq", is_equal, 0);
        chk("mm_cnt", fail_count, 1);
        chk("mm_vld", fail_valid, 1);
        chk("mm_addr", fail_addr, 5);
        chk("mm_data", fail_data, 8'hFB);
        chk("mm_ctr_clr", mem_addr, 0);
        tick();
        #1 chk("eq_hold", is_equal, 0);
        fail_ready = 1'b1;
        tick();
        fail_ready = 1'b0;
        #1;
        chk("pop_vld", fail_valid, 0);
        chk("pop_cnt", fail_count, 1);

        single_read(2, 1'b1, 8'hFF);
        #1;
        chk("reok_eq", is_equal, 1);
        chk("reok_cnt", fail_count, 1);
        chk("reok_vld", fail_valid, 0);

        // Six back-to-back mismatches at addresses 8..13 into a 4-deep log.
        do_rst();
        goto_addr(8);
        for (int c = 0; c < 8; c++) begin
            read = (c < 6); en = (c < 6); up_down = 1'b1; out = 1'b0;
            mem_rdata = (c >= 2) ? 8'(8'h10 + c - 2) : 8'h00;
            tick();
        end
        read = 1'b0; en = 1'b0; mem_rdata = 8'h00;
        #1;
        chk("ovf_cnt", fail_count, 6);
        chk("ovf_flag", fail_overflow, 1);
        chk("ovf_vld", fail_valid, 1);
        for (int i = 0; i < 4; i++) begin
            fail_ready = 1'b1;
            #1;
            chk("ovf_addr", fail_addr, 8 + i);
            chk("ovf_data", fail_data, 8'h10 + i);
            tick();
        end
        fail_ready = 1'b0;
        #1 chk("ovf_empty", fail_valid, 0);

        // Async reset with a logged entry and a read in flight.
        single_read(4, 1'b0, 8'h55);
        #1;
        chk("ar_pre_vld", fail_valid, 1);
        chk("ar_pre_ovf", fail_overflow, 1);
        read = 1'b1; out = 1'b0;
        tick();
        read = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_vld", fail_valid, 0);
        chk("ar_cnt", fail_count, 0);
        chk("ar_eq", is_equal, 1);
        chk("ar_ovf", fail_overflow, 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_faddr", fail_addr, 0);
        chk("ar_fdata", fail_data, 0);
        @(negedge clk);
        rst = 1'b0; mem_rdata = 8'h33;
        repeat (3) tick();
        mem_rdata = 8'h00;
        #1;
        chk("ar_post_cnt", fail_count, 0);
        chk("ar_post_eq", is_equal, 1);
        chk("ar_post_vld", fail_valid, 0);

        // Fill the log exactly, then push and pop in the same cycle.
        goto_addr(0);
        for (int c = 0; c < 6; c++) begin
            read = (c < 4); en = (c < 4); up_down = 1'b1; out = 1'b0;
            mem_rdata = (c >= 2) ? 8'(8'h20 + c - 2) : 8'h00;
            tick();
        end
        read = 1'b0; en = 1'b0; mem_rdata = 8'h00;
        #1;
        chk("full_cnt", fail_count, 4);
        chk("full_ovf", fail_overflow, 0);
        chk("full_addr", fail_addr, 0);
        chk("full_data", fail_data, 8'h20);
        goto_addr(7);
        read = 1'b1; out = 1'b0;
        tick();
        read = 1'b0;
        tick();
        mem_rdata = 8'hAA; fail_ready = 1'b1;
        tick();
        mem_rdata = 8'h00; fail_ready = 1'b0;
        #1;
        chk("pp_ovf", fail_overflow, 0);
        chk("pp_cnt", fail_count, 5);
        chk("pp_vld", fail_valid, 1);
        chk("pp_addr", fail_addr, 1);
        chk("pp_data", fail_data, 8'h21);
        for (int i = 0; i < 4; i++) begin
            fail_ready = 1'b1;
            #1;
            chk("pp_drain_addr", fail_addr, exp_a[i]);
            chk("pp_drain_data", fail_data, exp_d[i]);
            tick();
        end
        fail_ready = 1'b0;
        #1 chk("pp_empty", fail_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
